// File: rtl/bitbal_pkg.sv
// Shared constants, state encoding and word helpers for the bit-balancing blocks.
package bitbal_pkg;
  localparam int WIDTH = 8;
  localparam int IDX_W = 7;
  localparam int K_MAX = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Smallest word with kk ones: kk ones packed at the bottom.
  function automatic logic [WIDTH-1:0] first_word(input logic [3:0] kk);
    return WIDTH'((9'd1 << kk) - 9'd1);
  endfunction

  // Largest word with kk ones: kk ones packed at the top (0x00 for kk=0).
  function automatic logic [WIDTH-1:0] last_word(input logic [3:0] kk);
    return first_word(kk) << (4'd8 - kk);
  endfunction
endpackage

// File: rtl/tz_count8.sv
// Trailing-zero count of an 8-bit word; a zero input returns 0.
module tz_count8 (
  input  logic [7:0] x_i,
  output logic [2:0] tz_o
);
  // Scan from the top so the lowest set bit wins.
  always_comb begin
    tz_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (x_i[i]) tz_o = 3'(i);
    end
  end
endmodule

// File: rtl/ones_pattern_generator.sv
// Emits every 8-bit word with exactly k ones, ascending, one per handshake.
module ones_pattern_generator
  import bitbal_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       k,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             last,
  output logic [IDX_W-1:0] index,
  output logic             busy,
  output logic             error
);
  state_e           state_q;
  logic [3:0]       k_q;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;
  logic             err_q;
  logic [2:0]       tz;
  logic [WIDTH:0]   x9, c9, r9;

  tz_count8 u_tz (
    .x_i  (word_q),
    .tz_o (tz)
  );

  // Gosper's next-combination step in 9 bits; the carry out of r9 is dropped.
  always_comb begin
    x9     = {1'b0, word_q};
    c9     = x9 & (~x9 + 9'd1);
    r9     = x9 + c9;
    word_d = WIDTH'(r9 | (((x9 ^ r9) >> 2) >> tz));
  end

  // Sequencer: loads the first word on start, steps on each handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= 4'd0;
      word_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (k <= 4'(K_MAX)) begin
              k_q     <= k;
              word_q  <= first_word(k);
              idx_q   <= '0;
              last_q  <= (first_word(k) == last_word(k));
              state_q <= ST_EMIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              last_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              word_q <= word_d;
              idx_q  <= idx_q + IDX_W'(1);
              last_q <= (word_d == last_word(k_q));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_EMIT);
  assign out_valid = (state_q == ST_EMIT);
  assign out       = word_q;
  assign index     = idx_q;
  assign last      = last_q;
  assign error     = err_q;
endmodule

// File: tb/tb_ones_pattern_generator.sv
// Bench for ones_pattern_generator: enumeration model plus directed runs.
module tb_ones_pattern_generator;
  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] k;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out;
  logic       last;
  logic [6:0] index;
  logic       busy;
  logic       error;

  int total = 0;
  int bad   = 0;

  ones_pattern_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k         (k),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out       (out),
    .last      (last),
    .index     (index),
    .busy      (busy),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the remaining words of the current sequence, built by enumerating
  // all 256 words and keeping those whose popcount equals k.
  logic [7:0] m_q[$];
  int         m_idx = 0;
  bit         m_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_idx <= 0;
      m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_q.size() == 0) begin
        if (start) begin
          if (k <= 4'd8) begin
            for (int w = 0; w < 256; w++)
              if ($countones(w) == int'(k)) m_q.push_back(8'(w));
            m_idx <= 0;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (out_ready) begin
        void'(m_q.pop_front());
        m_idx <= m_idx + 1;
      end
    end
  end

  // Consumer side: every accepted word, in order.
  logic [7:0] acc_w[$];
  bit         acc_l[$];
  int         acc_i[$];

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      acc_w.push_back(out);
      acc_l.push_back(last);
      acc_i.push_back(int'(index));
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  task automatic compare_cycle();
    if (m_q.size() > 0) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("word", 32'(out), 32'(m_q[0]));
      chk("index", 32'(index), 32'(m_idx));
      chk("last", 32'(last), 32'(m_q.size() == 1));
      chk("busy", 32'(busy), 32'd1);
    end else begin
      chk("valid_idle", 32'(out_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
    chk("error", 32'(error), 32'(m_err));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic do_start(input logic [3:0] kk);
    start = 1'b1;
    k     = kk;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int b;
    b = 0;
    while (m_q.size() != 0 && b < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      b++;
    end
    chk("drain_bound", 32'(b < 1000), 32'd1);
  endtask

  // Checks the words accepted since base: count, endpoints, strict ascent,
  // popcount, index ordinal and a single trailing last.
  task automatic check_seq(input string nm, input int base, input int kk, input int n,
                           input logic [7:0] w0, input logic [7:0] wl);
    int cnt;
    bit ok;
    cnt = acc_w.size() - base;
    chk({nm, "_count"}, 32'(cnt), 32'(n));
    if (cnt > 0) begin
      chk({nm, "_first"}, 32'(acc_w[base]), 32'(w0));
      chk({nm, "_final"}, 32'(acc_w[base+cnt-1]), 32'(wl));
      ok = 1'b1;
      for (int i = 0; i < cnt; i++) begin
        if ($countones(acc_w[base+i]) != kk) ok = 1'b0;
        if (acc_i[base+i] != i) ok = 1'b0;
        if (acc_l[base+i] != (i == cnt - 1)) ok = 1'b0;
        if (i > 0 && acc_w[base+i] <= acc_w[base+i-1]) ok = 1'b0;
      end
      chk({nm, "_order"}, 32'(ok), 32'd1);
    end
  endtask

  initial begin
    int base;
    int b;
    logic [7:0] k2[7];
    k2 = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11};

    reset = 1'b1; start = 1'b0; k = 4'd0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // k=2, ready held high
    base = acc_w.size();
    do_start(4'd2);
    chk("k2_first_latency", 32'(out_valid), 32'd1);
    drain(1'b0);
    check_seq("k2", base, 2, 28, 8'h03, 8'hC0);
    if (acc_w.size() - base == 28) begin
      for (int i = 0; i < 7; i++) chk("k2_word_lit", 32'(acc_w[base+i]), 32'(k2[i]));
      chk("k2_last_idx", 32'(acc_i[base+27]), 32'd27);
    end
    tick();

    // back-to-back single-word sequences: k=0 then k=8
    base = acc_w.size();
    do_start(4'd0);
    chk("k0_last", 32'(last), 32'd1);
    drain(1'b0);
    check_seq("k0", base, 0, 1, 8'h00, 8'h00);
    base = acc_w.size();
    do_start(4'd8);
    chk("k8_last", 32'(last), 32'd1);
    drain(1'b0);
    check_seq("k8", base, 8, 1, 8'hFF, 8'hFF);
    tick();
    chk("k8_idle_busy", 32'(busy), 32'd0);

    // k=9 rejected, then k=1 runs normally
    do_start(4'd9);
    chk("k9_error", 32'(error), 32'd1);
    chk("k9_valid", 32'(out_valid), 32'd0);
    chk("k9_busy", 32'(busy), 32'd0);
    tick();
    chk("k9_error_drop", 32'(error), 32'd0);
    base = acc_w.size();
    do_start(4'd1);
    drain(1'b0);
    check_seq("k1", base, 1, 8, 8'h01, 8'h80);
    tick();

    // k=4 with random backpressure
    base = acc_w.size();
    do_start(4'd4);
    drain(1'b1);
    check_seq("k4", base, 4, 70, 8'h0F, 8'hF0);
    out_ready = 1'b1;
    tick();

    // reset in the middle of a k=3 run
    do_start(4'd3);
    b = 0;
    while (index !== 7'd10 && b < 100) begin
      out_ready = 1'b1;
      tick();
      b++;
    end
    chk("k3_reach_idx10", 32'(b < 100), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_out", 32'(out), 32'h00);
    chk("mid_rst_index", 32'(index), 32'd0);
    chk("mid_rst_last", 32'(last), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    base = acc_w.size();
    do_start(4'd3);
    chk("k3_restart_word", 32'(out), 32'h07);
    chk("k3_restart_idx", 32'(index), 32'd0);
    drain(1'b0);
    check_seq("k3", base, 3, 56, 8'h07, 8'hE0);
    tick();

    // start with k=5 during an active k=1 run is ignored
    base = acc_w.size();
    do_start(4'd1);
    out_ready = 1'b1;
    tick();
    tick();
    start = 1'b1;
    k = 4'd5;
    tick();
    start = 1'b0;
    k = 4'd0;
    drain(1'b0);
    check_seq("k1_ign", base, 1, 8, 8'h01, 8'h80);
    tick();
    chk("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
